// File: rtl/gaussian_line_buffer.sv
// rtl/gaussian_line_buffer.sv - 5-line vertical window generator feeding the 5x5 Gaussian core
module gaussian_line_buffer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int COL_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   valid_in,
    input  logic                   sof_in,
    output logic [PIXEL_WIDTH-1:0] win_row_0,
    output logic [PIXEL_WIDTH-1:0] win_row_1,
    output logic [PIXEL_WIDTH-1:0] win_row_2,
    output logic [PIXEL_WIDTH-1:0] win_row_3,
    output logic [PIXEL_WIDTH-1:0] win_row_4,
    output logic                   win_valid,
    output logic                   win_eol
);
    localparam logic [COL_WIDTH-1:0] LAST_COL   = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [2:0]           FULL_LINES = 3'd4;

    logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb2 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb3 [IMG_WIDTH];

    logic [COL_WIDTH-1:0] col;
    logic [COL_WIDTH-1:0] c;
    logic [2:0]           line_cnt;
    logic [2:0]           l_eff;
    logic                 at_eol;
    logic                 fill_done;

    // A start-of-frame pixel is always column 0 of line 0, whatever the counters hold
    always_comb begin
        c         = sof_in ? '0 : col;
        l_eff     = sof_in ? '0 : line_cnt;
        at_eol    = (c == LAST_COL);
        fill_done = (l_eff == FULL_LINES);
    end

    // Line memories carry no reset; line_cnt gating keeps stale contents from being flagged valid
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb0[c] <= pixel_in;
            lb1[c] <= lb0[c];
            lb2[c] <= lb1[c];
            lb3[c] <= lb2[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row_0 <= '0;
            win_row_1 <= '0;
            win_row_2 <= '0;
            win_row_3 <= '0;
            win_row_4 <= '0;
            win_valid <= 1'b0;
            win_eol   <= 1'b0;
            col       <= '0;
            line_cnt  <= '0;
        end else if (valid_in) begin
            win_row_4 <= pixel_in;
            win_row_3 <= lb0[c];
            win_row_2 <= lb1[c];
            win_row_1 <= lb2[c];
            win_row_0 <= lb3[c];
            win_valid <= fill_done;
            win_eol   <= fill_done && at_eol;
            if (at_eol) begin
                col      <= '0;
                line_cnt <= fill_done ? FULL_LINES : l_eff + 3'd1;
            end else begin
                col      <= c + COL_WIDTH'(1);
                line_cnt <= l_eff;
            end
        end else begin
            win_valid <= 1'b0;
            win_eol   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gaussian_line_buffer.sv
// tb/tb_gaussian_line_buffer.sv - randomized and directed bench for gaussian_line_buffer
module tb_gaussian_line_buffer;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] pixel_in = '0;
    logic       valid_in = 1'b0;
    logic       sof_in = 1'b0;
    logic [7:0] win_row_0, win_row_1, win_row_2, win_row_3, win_row_4;
    logic       win_valid, win_eol;

    int total = 0;
    int bad = 0;

    gaussian_line_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(W), .COL_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in), .sof_in(sof_in),
        .win_row_0(win_row_0), .win_row_1(win_row_1), .win_row_2(win_row_2),
        .win_row_3(win_row_3), .win_row_4(win_row_4), .win_valid(win_valid), .win_eol(win_eol)
    );

    always #5 clk = ~clk;

    logic [7:0] dut_row [5];
    assign dut_row[0] = win_row_0;
    assign dut_row[1] = win_row_1;
    assign dut_row[2] = win_row_2;
    assign dut_row[3] = win_row_3;
    assign dut_row[4] = win_row_4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rows(input string name, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3, input logic [7:0] r4);
        chk({name, ".row0"}, win_row_0, r0);
        chk({name, ".row1"}, win_row_1, r1);
        chk({name, ".row2"}, win_row_2, r2);
        chk({name, ".row3"}, win_row_3, r3);
        chk({name, ".row4"}, win_row_4, r4);
    endtask

    // Reference: the frame is a flat list of accepted pixels; line/column come from the index
    logic [7:0] hist [$];
    logic [7:0] exp_row [5];
    bit         known [5];
    bit         exp_valid, exp_eol;
    bit         compare_on = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (valid_in) begin
                int idx, ln, cl;
                if (sof_in) hist.delete();
                idx = hist.size();
                ln = idx / W;
                cl = idx % W;
                exp_row[4] = pixel_in;
                known[4] = 1;
                for (int k = 1; k <= 4; k++) begin
                    known[4-k] = (ln >= k);
                    if (ln >= k) exp_row[4-k] = hist[idx - k*W];
                end
                hist.push_back(pixel_in);
                exp_valid = (ln >= 4);
                exp_eol = exp_valid && (cl == W-1);
            end else begin
                exp_valid = 0;
                exp_eol = 0;
            end
        end
    end

    always @(negedge rst_n) begin
        hist.delete();
        for (int k = 0; k < 5; k++) begin
            exp_row[k] = '0;
            known[k] = 1;
        end
        exp_valid = 0;
        exp_eol = 0;
    end

    always @(negedge clk) begin
        if (rst_n && compare_on) begin
            chk("cmp.valid", win_valid, exp_valid);
            chk("cmp.eol", win_eol, exp_eol);
            for (int k = 0; k < 5; k++)
                if (known[k]) chk($sformatf("cmp.row%0d", k), dut_row[k], exp_row[k]);
        end
    end

    task automatic send(input logic [7:0] p, input bit s);
        valid_in = 1'b1;
        pixel_in = p;
        sof_in = s;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sof_in = 1'b0;
    endtask

    task automatic bubble();
        valid_in = 1'b0;
        sof_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int idx);
        return 8'((idx / W) * 16 + (idx % W));
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        #12;
        chk("reset.valid", win_valid, 0);
        chk("reset.eol", win_eol, 0);
        chk_rows("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        compare_on = 1;

        for (int i = 0; i < 32; i++) send(pat(i), i == 0);
        chk("fill32.valid", win_valid, 0);

        send(pat(32), 0);
        chk("first.valid", win_valid, 1);
        chk("first.eol", win_eol, 0);
        chk_rows("first", 8'h00, 8'h10, 8'h20, 8'h30, 8'h40);

        for (int i = 33; i < 40; i++) send(pat(i), 0);
        chk("eol.eol", win_eol, 1);
        chk_rows("eol", 8'h07, 8'h17, 8'h27, 8'h37, 8'h47);

        send(pat(40), 0);
        chk("wrap.eol", win_eol, 0);
        chk_rows("wrap", 8'h10, 8'h20, 8'h30, 8'h40, 8'h50);

        for (int i = 41; i < 44; i++) send(pat(i), 0);
        for (int b = 0; b < 3; b++) begin
            bubble();
            chk("bubble.valid", win_valid, 0);
            chk_rows("bubble", 8'h13, 8'h23, 8'h33, 8'h43, 8'h53);
        end
        send(pat(44), 0);
        chk("resume.valid", win_valid, 1);
        chk_rows("resume", 8'h14, 8'h24, 8'h34, 8'h44, 8'h54);

        for (int i = 45; i < 51; i++) send(pat(i), 0);
        send(pat(51), 1);
        for (int i = 1; i < 32; i++) send(8'($urandom), 0);
        chk("sof.valid32", win_valid, 0);
        send(8'($urandom), 0);
        chk("sof.valid33", win_valid, 1);
        for (int i = 33; i < 42; i++) send(8'($urandom), 0);

        #1 rst_n = 1'b0;
        #1;
        chk("areset.valid", win_valid, 0);
        chk_rows("areset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) send(8'($urandom), 0);
        chk("postreset.valid32", win_valid, 0);
        send(8'($urandom), 0);
        chk("postreset.valid33", win_valid, 1);

        for (int i = 0; i < 1500; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            sof_in = ($urandom_range(0, 249) == 0);
            pixel_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bubble();
        bubble();
        compare_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gaussian_line_buffer.md
# gaussian_line_buffer

Streaming 5-line window generator that feeds the 5x5 Gaussian core. It accepts a raster pixel stream at up to one pixel per clock and stores the four previous lines in internal line memories. For every accepted pixel it presents the vertically aligned column of five pixels (`win_row_0`, oldest line, through `win_row_4`, current line) together with a valid strobe. The core builds the horizontal taps itself from its sequential PE chain; `win_valid` drives the core's `enable`.

## Interface
- `PIXEL_WIDTH`, 8: bits per pixel.
- `IMG_WIDTH`, 640: pixels per line (fixed per build, ≥ 2).
- `COL_WIDTH`, 10: column counter width; must satisfy 2^COL_WIDTH ≥ IMG_WIDTH.

Ports:
- `clk`  in  1: single clock; all logic is posedge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `pixel_in`  in  PIXEL_WIDTH: raster pixel.
- `valid_in`  in  1: `pixel_in` is accepted this cycle. There is no backpressure.
- `sof_in`  in  1: start of frame, qualified by `valid_in`.
- `win_row_0` … `win_row_4`  out  PIXEL_WIDTH each: column taps, line n-4 … line n.
- `win_valid`  out  1: taps hold a valid 5-line column.
- `win_eol`  out  1: taps correspond to the last column of a line.

## Operation
- **State.**
  - `col` runs 0..IMG_WIDTH-1.
  - `line_cnt` runs 0..4 and saturates at 4.
  - Four line memories `lb0`..`lb3`, each IMG_WIDTH × PIXEL_WIDTH. `lb0` holds the previous line and `lb3` the oldest.
- **Accept.** An accepted pixel is one with `valid_in`=1. Let `c` be the effective column: 0 if `sof_in`=1, otherwise `col`.
  - Taps: `win_row_4`←`pixel_in`, `win_row_3`←`lb0[c]`, `win_row_2`←`lb1[c]`, `win_row_1`←`lb2[c]`, `win_row_0`←`lb3[c]`.
  - Cascade write: `lb0[c]`←`pixel_in`, `lb1[c]`←old `lb0[c]`, `lb2[c]`←old `lb1[c]`, `lb3[c]`←old `lb2[c]`. Every memory is read before it is written at the same address in the same cycle.
- **Counters.** The effective line count `L` is 0 if `sof_in`=1, otherwise `line_cnt`.
  - If `c`=IMG_WIDTH-1: `col`←0 and `line_cnt`←min(`L`+1, 4).
  - Otherwise: `col`←`c`+1 and `line_cnt`←`L`.
- **Valid.**
  - `win_valid`←1 on an accepted pixel with `L`=4, else 0.
  - `win_eol`←`win_valid_next` AND (`c`=IMG_WIDTH-1).
- **Bubbles.** In a cycle with `valid_in`=0:
  - Taps, counters and memories hold.
  - `win_valid` and `win_eol` go 0.
- **sof_in.** `sof_in` with `valid_in`=0 is ignored. `sof_in` in mid-line or mid-frame restarts at line 0 column 0. Stale memory contents are never flagged valid, because `line_cnt` gating prevents it.
- **Memories.** Memories are not reset; their contents are don't-care until overwritten.

## Timing
- Latency: 1 cycle from an accepted pixel to the taps, `win_valid` and `win_eol`.
- Throughput: 1 pixel/clk sustained, with arbitrary bubbles.
- First valid window: accepted pixel number 4·IMG_WIDTH+1 of a frame (line 4, column 0). From then on, every accepted pixel of the frame produces a valid window.
- Reset values: all `win_row_*`=0, `win_valid`=0, `win_eol`=0, `col`=0, `line_cnt`=0. All of these take effect immediately on `rst_n` falling, independent of `clk`.
- Reset mid-line: the next accepted pixel is column 0 of line 0, and no valid output follows for 4·IMG_WIDTH pixels.
- No combinational path from inputs to outputs.
- Memory read must be usable in the same cycle (distributed RAM/registers), or the read must be pre-issued so that the 1-cycle latency holds.

## Test plan
Unless stated otherwise: IMG_WIDTH=8, pixel value = row·16+col, `sof_in` on the first pixel.
1. **Reset.** Hold `rst_n`=0 → all outputs 0. Release, then send 32 pixels → `win_valid` stays 0 throughout.
2. **First window.** 33rd accepted pixel (0x40) → next cycle `win_valid`=1 and rows 0..4 = 0x00, 0x10, 0x20, 0x30, 0x40, with `win_eol`=0.
3. **End of line.** Pixel 0x47 (line 4, column 7) → `win_eol`=1 and rows = 0x07, 0x17, 0x27, 0x37, 0x47. The next pixel 0x50 → rows = 0x10, 0x20, 0x30, 0x40, 0x50.
4. **Bubbles.**
   - Drop `valid_in` for 3 cycles after pixel 0x53 → `win_valid`=0 and taps hold 0x53's column.
   - Resume with 0x54 → rows = 0x14, 0x24, 0x34, 0x44, 0x54.
5. **Mid-frame sof.** `sof_in` with the pixel at line 6, column 3 → `win_valid`=0 for the next 32 accepted pixels, and =1 on the 33rd.
6. **Async reset mid-line.** Pulse `rst_n` low between clock edges at line 5, column 2 → outputs 0 immediately. The following pixel restarts at column 0 of line 0, and no `win_valid` appears for 32 pixels.
